// File: rtl/oled_pkg.sv
`default_nettype none
// =============================================================================
// Module      : oled_pkg
// Description : Shared constants, init command list and state encodings for
//               the SSD1306 SPI OLED power-up / command sequencer.
// Revision    : 1.0
// =============================================================================
package oled_pkg;

    localparam int INIT_LEN = 11;
    localparam int IDX_W    = $clog2(INIT_LEN);

    // Entry 0 sits in the least significant byte.
    localparam logic [INIT_LEN*8-1:0] INIT_ROM = {
        8'h20, 8'hDA, 8'hC8, 8'hA1, 8'h0F, 8'h81,
        8'hF1, 8'hD9, 8'h14, 8'h8D, 8'hAE
    };

    localparam logic [7:0] CMD_DISP_ON = 8'hAF;

    typedef enum logic [2:0] {
        ST_PWR_VDD  = 3'd0,
        ST_RST_LOW  = 3'd1,
        ST_RST_WAIT = 3'd2,
        ST_INIT_CMD = 3'd3,
        ST_PWR_VBAT = 3'd4,
        ST_DISP_ON  = 3'd5,
        ST_READY    = 3'd6
    } main_state_t;

    typedef enum logic [1:0] {
        HS_IDLE      = 2'd0,
        HS_LOAD      = 2'd1,
        HS_WAIT_DONE = 2'd2,
        HS_WAIT_CLR  = 2'd3
    } hs_state_t;

    function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] idx);
        return INIT_ROM[int'(idx)*8 +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/oled_byte_handshake.sv
`default_nettype none
// =============================================================================
// Module      : oled_byte_handshake
// Description : Four-phase load/done master towards the SPI byte sender, with
//               a two-flop synchronizer on the sender's done flag.
// Revision    : 1.0
// =============================================================================
module oled_byte_handshake
    import oled_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_start,
    input  logic i_done,
    output logic o_load,
    output logic o_busy,
    output logic o_finish
);

    logic      r_sync1;
    logic      r_sync2;
    hs_state_t r_state;
    hs_state_t w_state_nxt;
    logic      r_load;
    logic      w_load_nxt;
    logic      r_finish;
    logic      w_finish_nxt;

    // done arrives from the slow SPI clock domain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_done;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= HS_IDLE;
            r_load   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_load   <= w_load_nxt;
            r_finish <= w_finish_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_nxt   = r_load;
        w_finish_nxt = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (i_start) begin
                    w_state_nxt = HS_LOAD;
                    w_load_nxt  = 1'b1;
                end
            end
            HS_LOAD: begin
                w_state_nxt = HS_WAIT_DONE;
            end
            HS_WAIT_DONE: begin
                if (r_sync2) begin
                    w_state_nxt = HS_WAIT_CLR;
                    w_load_nxt  = 1'b0;
                end
            end
            HS_WAIT_CLR: begin
                if (!r_sync2) begin
                    w_state_nxt  = HS_IDLE;
                    w_finish_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HS_IDLE;
                w_load_nxt  = 1'b0;
            end
        endcase
    end

    assign o_load   = r_load;
    assign o_busy   = (r_state != HS_IDLE);
    assign o_finish = r_finish;

endmodule
`default_nettype wire

// File: rtl/oled_spi_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : oled_spi_sequencer
// Description : Panel power/reset sequencing, init command stream and host
//               byte forwarding for an SSD1306-class SPI OLED.
// Revision    : 1.0
// =============================================================================
module oled_spi_sequencer
    import oled_pkg::*;
#(
    parameter int VDD_DELAY   = 100000,
    parameter int RST_CYCLES  = 1000,
    parameter int RST_RECOVER = 1000,
    parameter int VBAT_DELAY  = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] byte_data,
    output logic       byte_load,
    input  logic       byte_done,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       oled_vdd_n,
    output logic       oled_vbat_n,
    output logic       init_done,
    input  logic       host_valid,
    input  logic       host_dc,
    input  logic [7:0] host_data,
    output logic       host_ready
);

    localparam int MAX_A     = (VDD_DELAY > RST_CYCLES) ? VDD_DELAY : RST_CYCLES;
    localparam int MAX_B     = (RST_RECOVER > VBAT_DELAY) ? RST_RECOVER : VBAT_DELAY;
    localparam int MAX_DELAY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    main_state_t      r_state;
    main_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_issued;
    logic             w_issued_nxt;
    logic [7:0]       r_byte_data;
    logic [7:0]       w_byte_data_nxt;
    logic             r_dc;
    logic             w_dc_nxt;
    logic             r_res_n;
    logic             w_res_n_nxt;
    logic             r_vdd_n;
    logic             w_vdd_n_nxt;
    logic             r_vbat_n;
    logic             w_vbat_n_nxt;
    logic             r_init_done;
    logic             w_init_done_nxt;
    logic             r_host_ready;
    logic             w_host_ready_nxt;
    logic             w_start;
    logic             w_hs_load;
    logic             w_hs_busy;
    logic             w_hs_finish;

    // A delay of 0 still spends one cycle in the state.
    function automatic logic delay_done(input logic [CNT_W-1:0] cnt, input int dly);
        return (int'(cnt) + 1 >= dly);
    endfunction

    oled_byte_handshake u_handshake (
        .clock    (clock),
        .reset    (reset),
        .i_start  (w_start),
        .i_done   (byte_done),
        .o_load   (w_hs_load),
        .o_busy   (w_hs_busy),
        .o_finish (w_hs_finish)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_PWR_VDD;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_issued     <= 1'b0;
            r_byte_data  <= 8'h00;
            r_dc         <= 1'b0;
            r_res_n      <= 1'b1;
            r_vdd_n      <= 1'b1;
            r_vbat_n     <= 1'b1;
            r_init_done  <= 1'b0;
            r_host_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= (w_state_nxt != r_state) ? '0 :
                            ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
            r_idx        <= w_idx_nxt;
            r_issued     <= w_issued_nxt;
            r_byte_data  <= w_byte_data_nxt;
            r_dc         <= w_dc_nxt;
            r_res_n      <= w_res_n_nxt;
            r_vdd_n      <= w_vdd_n_nxt;
            r_vbat_n     <= w_vbat_n_nxt;
            r_init_done  <= w_init_done_nxt;
            r_host_ready <= w_host_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_issued_nxt     = r_issued;
        w_byte_data_nxt  = r_byte_data;
        w_dc_nxt         = r_dc;
        w_init_done_nxt  = r_init_done;
        w_host_ready_nxt = r_host_ready;
        w_start          = 1'b0;
        // Pin levels follow the state one register stage later.
        w_vdd_n_nxt      = 1'b0;
        w_res_n_nxt      = (r_state != ST_RST_LOW);
        w_vbat_n_nxt     = !((r_state == ST_PWR_VBAT) || (r_state == ST_DISP_ON) ||
                             (r_state == ST_READY));
        case (r_state)
            ST_PWR_VDD: begin
                if (delay_done(r_cnt, VDD_DELAY)) w_state_nxt = ST_RST_LOW;
            end
            ST_RST_LOW: begin
                if (delay_done(r_cnt, RST_CYCLES)) w_state_nxt = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                if (delay_done(r_cnt, RST_RECOVER)) w_state_nxt = ST_INIT_CMD;
            end
            ST_INIT_CMD: begin
                if (w_hs_finish) begin
                    w_issued_nxt = 1'b0;
                    if (r_idx == IDX_W'(INIT_LEN - 1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_PWR_VBAT;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else if (!r_issued && !w_hs_busy) begin
                    w_start         = 1'b1;
                    w_issued_nxt    = 1'b1;
                    w_byte_data_nxt = init_cmd(r_idx);
                    w_dc_nxt        = 1'b0;
                end
            end
            ST_PWR_VBAT: begin
                if (delay_done(r_cnt, VBAT_DELAY)) w_state_nxt = ST_DISP_ON;
            end
            ST_DISP_ON: begin
                if (w_hs_finish) begin
                    w_issued_nxt     = 1'b0;
                    w_init_done_nxt  = 1'b1;
                    w_host_ready_nxt = 1'b1;
                    w_state_nxt      = ST_READY;
                end else if (!r_issued && !w_hs_busy) begin
                    w_start         = 1'b1;
                    w_issued_nxt    = 1'b1;
                    w_byte_data_nxt = CMD_DISP_ON;
                    w_dc_nxt        = 1'b0;
                end
            end
            ST_READY: begin
                if (w_hs_finish) begin
                    w_host_ready_nxt = 1'b1;
                end else if (host_valid && r_host_ready) begin
                    w_start          = 1'b1;
                    w_host_ready_nxt = 1'b0;
                    w_byte_data_nxt  = host_data;
                    w_dc_nxt         = host_dc;
                end
            end
            default: begin
                w_state_nxt = ST_PWR_VDD;
            end
        endcase
    end

    assign byte_data   = r_byte_data;
    assign byte_load   = w_hs_load;
    assign oled_dc     = r_dc;
    assign oled_res_n  = r_res_n;
    assign oled_vdd_n  = r_vdd_n;
    assign oled_vbat_n = r_vbat_n;
    assign init_done   = r_init_done;
    assign host_ready  = r_host_ready;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : tb_oled_spi_sequencer
// Description : Directed self-checking bench for the OLED sequencer with a
//               byte-sender model (done 40 cycles after load, clear 3 after drop).
// Revision    : 1.0
// =============================================================================
module tb_oled_spi_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_data;
    logic       byte_load;
    logic       byte_done;
    logic       oled_dc;
    logic       oled_res_n;
    logic       oled_vdd_n;
    logic       oled_vbat_n;
    logic       init_done;
    logic       host_valid = 1'b0;
    logic       host_dc = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_ready;

    always #5 clock = ~clock;

    oled_spi_sequencer #(
        .VDD_DELAY   (10),
        .RST_CYCLES  (5),
        .RST_RECOVER (5),
        .VBAT_DELAY  (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .byte_data   (byte_data),
        .byte_load   (byte_load),
        .byte_done   (byte_done),
        .oled_dc     (oled_dc),
        .oled_res_n  (oled_res_n),
        .oled_vdd_n  (oled_vdd_n),
        .oled_vbat_n (oled_vbat_n),
        .init_done   (init_done),
        .host_valid  (host_valid),
        .host_dc     (host_dc),
        .host_data   (host_data),
        .host_ready  (host_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_init [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                  8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

    always @(posedge clock) cyc <= cyc + 1;

    // Byte-sender model
    int ld_cnt = 0;
    int clr_cnt = 0;
    always @(posedge clock) begin
        if (reset) begin
            byte_done <= 1'b0;
            ld_cnt    <= 0;
            clr_cnt   <= 0;
        end else if (byte_load) begin
            clr_cnt <= 0;
            ld_cnt  <= ld_cnt + 1;
            if (ld_cnt + 1 >= 40) byte_done <= 1'b1;
        end else begin
            ld_cnt <= 0;
            if (byte_done) begin
                clr_cnt <= clr_cnt + 1;
                if (clr_cnt + 1 >= 3) byte_done <= 1'b0;
            end else begin
                clr_cnt <= 0;
            end
        end
    end

    // Edge monitor, sampled mid-cycle on the falling clock edge
    logic       p_load, p_vdd_n, p_res_n, p_vbat_n, p_init, p_dc;
    logic [7:0] p_data;
    logic [7:0] cap_data [$];
    logic       cap_dc [$];
    int         cap_t [$];
    int t_vdd_fall = -1, t_res_fall = -1, t_res_rise = -1;
    int t_vbat_fall = -1, n_at_vbat = -1, t_init_done = -1;

    always begin
        @(negedge clock);
        if (reset) begin
            p_load = 1'b0; p_vdd_n = 1'b1; p_res_n = 1'b1; p_vbat_n = 1'b1;
            p_init = 1'b0; p_dc = 1'b0; p_data = 8'h00;
        end else begin
            if (p_vdd_n && !oled_vdd_n) t_vdd_fall = cyc;
            if (p_res_n && !oled_res_n) t_res_fall = cyc;
            if (!p_res_n && oled_res_n) t_res_rise = cyc;
            if (p_vbat_n && !oled_vbat_n) begin
                t_vbat_fall = cyc;
                n_at_vbat   = cap_data.size();
            end
            if (!p_init && init_done) t_init_done = cyc;
            if (byte_load && !p_load) begin
                cap_data.push_back(byte_data);
                cap_dc.push_back(oled_dc);
                cap_t.push_back(cyc);
            end
            if (byte_load && p_load) begin
                total++;
                if (byte_data !== p_data || oled_dc !== p_dc) begin
                    bad++;
                    $display("FAIL hold: data/dc %h/%b changed during load, was %h/%b",
                             byte_data, oled_dc, p_data, p_dc);
                end
            end
            p_load = byte_load; p_vdd_n = oled_vdd_n; p_res_n = oled_res_n;
            p_vbat_n = oled_vbat_n; p_init = init_done; p_dc = oled_dc; p_data = byte_data;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_log();
        cap_data.delete(); cap_dc.delete(); cap_t.delete();
        t_vdd_fall = -1; t_res_fall = -1; t_res_rise = -1;
        t_vbat_fall = -1; n_at_vbat = -1; t_init_done = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL rst byte_data: got %h want 00", byte_data); end
        total++; if (byte_load !== 1'b0) begin bad++; $display("FAIL rst byte_load: got %b want 0", byte_load); end
        total++; if (oled_dc !== 1'b0) begin bad++; $display("FAIL rst oled_dc: got %b want 0", oled_dc); end
        total++; if (oled_res_n !== 1'b1) begin bad++; $display("FAIL rst res_n: got %b want 1", oled_res_n); end
        total++; if (oled_vdd_n !== 1'b1) begin bad++; $display("FAIL rst vdd_n: got %b want 1", oled_vdd_n); end
        total++; if (oled_vbat_n !== 1'b1) begin bad++; $display("FAIL rst vbat_n: got %b want 1", oled_vbat_n); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst init_done: got %b want 0", init_done); end
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL rst host_ready: got %b want 0", host_ready); end
    endtask

    // Releases reset and checks the power-up timeline relative to release.
    task automatic release_and_check_powerup(input string tag);
        int t_rel;
        clear_log();
        tick();
        #1 reset = 1'b0;
        t_rel = cyc;
        repeat (25) tick();
        total++; if (t_vdd_fall - t_rel !== 1) begin bad++; $display("FAIL %s vdd fall: got cycle %0d want 1", tag, t_vdd_fall - t_rel); end
        total++; if (t_res_fall - t_rel !== 11) begin bad++; $display("FAIL %s res fall: got cycle %0d want 11", tag, t_res_fall - t_rel); end
        total++; if (t_res_rise - t_res_fall !== 5) begin bad++; $display("FAIL %s res width: got %0d want 5", tag, t_res_rise - t_res_fall); end
        total++;
        if (cap_t.size() == 0) begin
            bad++; $display("FAIL %s first load: got none want cycle 21", tag);
        end else if (cap_t[0] - t_rel !== 21 || cap_data[0] !== 8'hAE) begin
            bad++; $display("FAIL %s first load: got cycle %0d byte %h want cycle 21 byte AE", tag, cap_t[0] - t_rel, cap_data[0]);
        end
    endtask

    task automatic test_power_up();
        release_and_check_powerup("pwr");
    endtask

    task automatic test_init_stream();
        int n = 0;
        while (!init_done && n < 3000) begin tick(); n++; end
        total++; if (!init_done) begin bad++; $display("FAIL init timeout: init_done got 0 want 1"); end
        total++;
        if (cap_data.size() !== 12) begin
            bad++; $display("FAIL init count: got %0d bytes want 12", cap_data.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (cap_data[i] !== exp_init[i] || cap_dc[i] !== 1'b0) begin
                    bad++; $display("FAIL init byte %0d: got %h dc=%b want %h dc=0", i, cap_data[i], cap_dc[i], exp_init[i]);
                end
            end
            total++; if (cap_t[11] - t_vbat_fall !== 20) begin bad++; $display("FAIL vbat->AF: got %0d want 20", cap_t[11] - t_vbat_fall); end
            total++; if (t_init_done <= cap_t[11]) begin bad++; $display("FAIL init_done early: got cycle %0d want after %0d", t_init_done, cap_t[11]); end
        end
        total++; if (n_at_vbat !== 11) begin bad++; $display("FAIL vbat order: got %0d bytes before vbat want 11", n_at_vbat); end
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL ready after init: got %b want 1", host_ready); end
    endtask

    task automatic test_host();
        int n = 0;
        int t_clr;
        clear_log();
        host_dc = 1'b1; host_data = 8'h5A; host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL host ready drop: got %b want 0", host_ready); end
        total++;
        if (byte_load !== 1'b1 || byte_data !== 8'h5A || oled_dc !== 1'b1) begin
            bad++; $display("FAIL host byte: got load=%b %h dc=%b want load=1 5A dc=1", byte_load, byte_data, oled_dc);
        end
        while (!byte_done && n < 200) begin tick(); n++; end
        while (byte_done && n < 200) begin tick(); n++; end
        t_clr = cyc;
        total++; if (host_ready !== 1'b0 || n >= 200) begin bad++; $display("FAIL host busy: ready=%b steps=%0d want ready=0 before done clears", host_ready, n); end
        n = 0;
        while (!host_ready && n < 20) begin tick(); n++; end
        total++; if (cyc - t_clr !== 4) begin bad++; $display("FAIL host ready return: got %0d cycles want 4", cyc - t_clr); end
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL host count: got %0d want 1", cap_data.size()); end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_log();
        host_dc = 1'b0; host_data = 8'h01; host_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!host_ready && n < 300) begin tick(); n++; end
            total++; if (n >= 300) begin bad++; $display("FAIL b2b wait %0d: got timeout want host_ready", i); end
            tick();
            if (i < 2) host_data = 8'(i + 2);
            else host_valid = 1'b0;
        end
        n = 0;
        while (!host_ready && n < 300) begin tick(); n++; end
        repeat (10) tick();
        total++;
        if (cap_data.size() !== 3) begin
            bad++; $display("FAIL b2b count: got %0d want 3", cap_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cap_data[i] !== 8'(i + 1) || cap_dc[i] !== 1'b0) begin
                    bad++; $display("FAIL b2b byte %0d: got %h dc=%b want %0h dc=0", i, cap_data[i], cap_dc[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        int n = 0;
        // Asynchronous drop from the fully initialised state
        tick();
        #1 reset = 1'b1;
        #1;
        total++; if (init_done !== 1'b0 || host_ready !== 1'b0) begin bad++; $display("FAIL async rst ready: init_done=%b host_ready=%b want 0/0", init_done, host_ready); end
        total++; if (oled_vdd_n !== 1'b1 || oled_vbat_n !== 1'b1) begin bad++; $display("FAIL async rst power: vdd_n=%b vbat_n=%b want 1/1", oled_vdd_n, oled_vbat_n); end
        release_and_check_powerup("restart1");
        while (cap_data.size() < 4 && n < 1000) begin tick(); n++; end
        repeat (5) tick();
        total++; if (byte_load !== 1'b1 || byte_done !== 1'b0 || cap_data.size() !== 4) begin
            bad++; $display("FAIL mid-init setup: load=%b done=%b bytes=%0d want 1/0/4", byte_load, byte_done, cap_data.size());
        end
        #1 reset = 1'b1;
        #1;
        total++; if (byte_load !== 1'b0) begin bad++; $display("FAIL mid rst load: got %b want 0", byte_load); end
        total++; if (oled_vdd_n !== 1'b1 || oled_res_n !== 1'b1 || oled_vbat_n !== 1'b1) begin
            bad++; $display("FAIL mid rst pins: vdd_n=%b res_n=%b vbat_n=%b want 1/1/1", oled_vdd_n, oled_res_n, oled_vbat_n);
        end
        total++; if (init_done !== 1'b0 || host_ready !== 1'b0) begin bad++; $display("FAIL mid rst flags: init_done=%b host_ready=%b want 0/0", init_done, host_ready); end
        repeat (3) tick();
        release_and_check_powerup("restart2");
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_init_stream();
        test_host();
        test_back_to_back();
        test_reset_mid_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oled_spi_sequencer.md
Name: oled_spi_sequencer

Overview:
- Controller that sequences the SPI byte transmitter for the clock's SPI OLED (SSD1306-class, 128x32).
- Drives panel power-up and reset timing, then streams a fixed init command list, then turns the display on.
- After that it arbitrates nothing: it forwards host (display-refresh logic) byte requests one at a time.
- Each byte goes to the byte sender through its load_data/done_send four-phase handshake.

Parameters:
- VDD_DELAY, 100000, clock cycles from VDD enable to reset assertion (1 ms at 100 MHz)
- RST_CYCLES, 1000, cycles oled_res_n is held low
- RST_RECOVER, 1000, cycles after reset release before first command
- VBAT_DELAY, 10000000, cycles from VBAT enable to display-on command (100 ms)

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high; the same reset drives the byte sender
- byte_data  out  8  byte presented to the byte sender
- byte_load  out  1  to sender load_data
- byte_done  in  1  from sender done_send
- oled_dc  out  1  0 = command, 1 = data; stable while byte_load is high
- oled_res_n  out  1  panel reset, active-low
- oled_vdd_n  out  1  logic supply enable, active-low
- oled_vbat_n  out  1  panel supply enable, active-low
- init_done  out  1  high once display-on has been sent
- host_valid  in  1  host byte request
- host_dc  in  1  D/C for the host byte
- host_data  in  8  host byte
- host_ready  out  1  sequencer can accept a host byte

Behaviour:
- Reset values: byte_data=0, byte_load=0, oled_dc=0, oled_res_n=1, oled_vdd_n=1, oled_vbat_n=1, init_done=0, host_ready=0.
- All outputs are registered. One delay counter, sized by $clog2 of the largest delay parameter.
- Main FSM: PWR_VDD -> RST_LOW -> RST_WAIT -> INIT_CMD -> PWR_VBAT -> DISP_ON -> READY.
- PWR_VDD:
  - Entered on reset release; oled_vdd_n=0.
  - Count VDD_DELAY cycles, then go to RST_LOW.
- RST_LOW: oled_res_n=0 for RST_CYCLES cycles, then oled_res_n=1.
- RST_WAIT: wait RST_RECOVER cycles.
- INIT_CMD:
  - idx runs 0..INIT_LEN-1 with oled_dc=0; each entry is sent via the byte subsequence.
  - Advance after each byte completes; after the last entry go to PWR_VBAT.
- PWR_VBAT: oled_vbat_n=0, wait VBAT_DELAY cycles.
- DISP_ON: send 0xAF with oled_dc=0, then set init_done=1 (sticky until reset) and go to READY.
- READY:
  - host_ready=1 when no byte is in flight.
  - On host_valid && host_ready: latch host_data/host_dc into byte_data/oled_dc; host_ready=0 on the next cycle; run the byte subsequence.
  - host_ready returns to 1 the cycle after the subsequence finishes.
  - host_valid while host_ready=0 is ignored; the host holds its request.
- Byte subsequence (nested states LOAD, WAIT_DONE, WAIT_CLR):
  - LOAD: byte_data/oled_dc already stable; set byte_load=1.
  - WAIT_DONE: hold byte_load until byte_done=1, then byte_load=0.
  - WAIT_CLR: wait until byte_done=0; the byte is then complete.
  - byte_data and oled_dc must not change from LOAD until WAIT_CLR exits.
- byte_done is from the slow SPI clock domain: pass it through a two-flop synchronizer before use.
- Minimum one-cycle gap between byte_load falling and the next byte_load rising.
- Reset mid-operation:
  - All state and outputs return to reset values immediately (asynchronously); byte_load drops.
  - Panel power is removed (vdd_n=vbat_n=1), and the full power-up sequence restarts on release.
- The delay counter saturates/clears on every state change; a delay parameter of 0 means one cycle in that state.

Decomposition:
- Package oled_pkg holds:
  - INIT_LEN = 11
  - INIT_ROM, the command list: AE, 8D, 14, D9, F1, 81, 0F, A1, C8, DA, 20
  - CMD_DISP_ON = 8'hAF
  - the main-FSM and byte-subsequence state encodings
- One sub-module, oled_byte_handshake: the LOAD/WAIT_DONE/WAIT_CLR four-phase master including the byte_done synchronizer, with start/busy/finish pins.

Test Plan:
- Bench uses VDD_DELAY=10, RST_CYCLES=5, RST_RECOVER=5, VBAT_DELAY=20, with a byte-sender model answering done_send 40 cycles after load and clearing 3 cycles after load drops.
- Power-up timing: release reset -> oled_vdd_n falls at cycle 1; oled_res_n low for exactly 5 cycles starting 10 cycles later; first byte_load 5 cycles after oled_res_n rises.
- Init stream: capture all byte_load-qualified bytes -> exactly AE,8D,14,D9,F1,81,0F,A1,C8,DA,20 with oled_dc=0; then oled_vbat_n falls; 20 cycles later AF is sent; init_done rises after AF completes.
- Host transfer: after init_done, host_valid=1, host_dc=1, host_data=0x5A -> host_ready drops next cycle; one byte 0x5A sent with oled_dc=1; host_ready returns after the sender clears done_send.
- Back-to-back host requests: 0x01, 0x02, 0x03 with host_valid held -> three sequential bytes in order, byte_load low at least one cycle between them, no byte dropped or duplicated.
- Reset mid-init: assert reset while waiting for done_send on the 4th init byte -> byte_load, init_done and host_ready go to 0 and vdd_n/vbat_n go to 1 without waiting for a clock edge; after release, the sequence restarts from PWR_VDD and re-sends AE first.
